// File: rtl/audioqsys_switch_poller.sv
`default_nettype none
// ============================================================================
// Module      : audioqsys_switch_poller
// Description : Poll sequencer and debouncer for the slide-switch PIO.
//               An Avalon-MM master reads PIO offset 0 once every POLL_DIV
//               clocks. Each sample goes through a debouncer that needs
//               STABLE_CNT identical consecutive samples. Every newly accepted
//               switch word is queued in a small event FIFO. A CPU-side
//               Avalon-MM slave gives access to the stable value, the FIFO
//               pop, control, status and a level interrupt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   system clock
//   reset_n      in   1   asynchronous reset, active-low
//   m_address    out  2   PIO address (always 0)
//   m_read       out  1   one-cycle read strobe per poll
//   m_readdata   in   32  PIO read data (bits [WIDTH-1:0] used)
//   s_address    in   2   CPU register select
//                         0 STABLE, 1 EVENT, 2 CTRL, 3 STATUS
//   s_read       in   1   CPU read strobe
//   s_write      in   1   CPU write strobe
//   s_writedata  in   32  CPU write data
//   s_readdata   out  32  registered read data, valid the cycle after s_read
//   irq          out  1   level interrupt
// Parameters
//   WIDTH      switch bits used, < 32
//   POLL_DIV   clocks between poll starts, >= READ_LAT+2
//   READ_LAT   PIO read latency in cycles, >= 1
//   STABLE_CNT identical samples needed to accept a value, 1..15
//   FIFO_DEPTH event FIFO entries, power of two, >= 2, <= 8
// ============================================================================
module audioqsys_switch_poller #(
    parameter int WIDTH      = 18,
    parameter int POLL_DIV   = 50000,
    parameter int READ_LAT   = 1,
    parameter int STABLE_CNT = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_poll_w = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    localparam int c_wait_w = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_DIV - 1);
    localparam logic [c_wait_w-1:0] c_wait_last =
        c_wait_w'((READ_LAT > 1) ? (READ_LAT - 2) : 0);
    localparam logic [3:0]          c_stable    = 4'(STABLE_CNT);
    localparam logic [c_cnt_w-1:0]  c_full      = c_cnt_w'(FIFO_DEPTH);

    localparam logic [1:0] c_reg_stable = 2'd0;
    localparam logic [1:0] c_reg_event  = 2'd1;
    localparam logic [1:0] c_reg_ctrl   = 2'd2;
    localparam logic [1:0] c_reg_status = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_poll_w-1:0] r_poll_cnt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_m_read;

    logic [WIDTH-1:0]    r_stable;
    logic [WIDTH-1:0]    r_cand;
    logic [3:0]          r_cnt;

    logic [WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_ovf;

    logic [1:0]          r_ctrl;
    logic [31:0]         r_rdata;
    logic                r_irq;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic                w_enable;
    logic                w_irq_en;
    logic                w_capture;
    logic [WIDTH-1:0]    w_sample;
    logic                w_diff;
    logic [WIDTH-1:0]    w_next_cand;
    logic [3:0]          w_next_cnt;
    logic                w_push;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_nonempty;
    logic                w_full;
    logic                w_ovf_set;
    logic                w_ovf_clr;
    logic [WIDTH-1:0]    w_head;
    logic [7:0]          w_count_ext;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_enable   = r_ctrl[0];
    assign w_irq_en   = r_ctrl[1];
    assign w_capture  = (r_state == S_CAPTURE);
    assign w_sample   = m_readdata[WIDTH-1:0];

    // Debounce next-state: a differing sample restarts the run at 1,
    // an identical one extends it, saturating at STABLE_CNT.
    assign w_diff      = (w_sample != r_cand);
    assign w_next_cand = w_diff ? w_sample : r_cand;
    assign w_next_cnt  = w_diff ? 4'd1 :
                         ((r_cnt == c_stable) ? r_cnt : r_cnt + 4'd1);

    // Accepting only when the candidate differs from the stable word makes
    // each change produce exactly one event.
    assign w_push = w_capture && (w_next_cnt == c_stable) &&
                    (w_next_cand != r_stable);

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == c_full);
    assign w_pop      = s_read && (s_address == c_reg_event) && w_nonempty;
    // A simultaneous pop frees the head slot, so a push into a full FIFO
    // still lands.
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_ovf_set  = w_push && w_full && !w_pop;
    assign w_ovf_clr  = s_write && (s_address == c_reg_status) && s_writedata[1];
    assign w_head     = r_mem[r_rd_ptr];
    assign w_count_ext = 8'(r_count);

    always_comb begin
        w_rdata = '0;
        case (s_address)
            c_reg_stable: w_rdata = {{(32-WIDTH){1'b0}}, r_stable};
            c_reg_event:  w_rdata = w_nonempty ?
                                    {1'b1, {(31-WIDTH){1'b0}}, w_head} : 32'h0;
            c_reg_ctrl:   w_rdata = {30'h0, r_ctrl};
            c_reg_status: w_rdata = {24'h0, w_count_ext[3:0], 2'b00,
                                     r_ovf, w_nonempty};
            default:      w_rdata = '0;
        endcase
    end

    assign w_unused = &{1'b0, m_readdata[31:WIDTH], s_writedata[31:2],
                        w_count_ext[7:4]};

    // ------------------------------------------------------------------------
    // Poll sequencer
    // The poll counter runs through the whole ISSUE/WAIT/CAPTURE sequence so
    // that poll starts are exactly POLL_DIV clocks apart; because the
    // sequence is shorter than POLL_DIV the FSM is always back in IDLE
    // before the counter wraps again. Clearing enable holds the counter at 0
    // but lets an in-flight sequence finish.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_poll_cnt <= '0;
            r_wait_cnt <= '0;
            r_m_read   <= 1'b0;
        end else begin
            if (!w_enable || (r_poll_cnt == c_poll_last)) begin
                r_poll_cnt <= '0;
            end else begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
            end

            r_m_read <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_enable && (r_poll_cnt == c_poll_last)) begin
                        r_state  <= S_ISSUE;
                        r_m_read <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= (READ_LAT == 1) ? S_CAPTURE : S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == c_wait_last) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
        end else if (w_capture) begin
            r_cand <= w_next_cand;
            r_cnt  <= w_next_cnt;
            if (w_push) begin
                r_stable <= w_next_cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Event FIFO
    // When full, wr_ptr equals rd_ptr; a push-with-pop overwrites the slot
    // being read this cycle, which then becomes the tail. Order is kept.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_next_cand;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Set has priority over a clear in the same cycle.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // CPU slave: control register, read data, interrupt
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl  <= 2'b00;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (s_write && (s_address == c_reg_ctrl)) begin
                r_ctrl <= s_writedata[1:0];
            end
            if (s_read) begin
                r_rdata <= w_rdata;
            end
            r_irq <= w_irq_en & (w_nonempty | r_ovf);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m_address  = 2'b00;
    assign m_read     = r_m_read;
    assign s_readdata = r_rdata;
    assign irq        = r_irq;

endmodule
`default_nettype wire
